// File: rtl/siphash_msg_ctrl.sv
// Message sequencer in front of a SipHash core: turns a valid/ready stream of
// little-endian 64-bit words into initalize/compress/finalize commands and a tag.
module siphash_msg_ctrl #(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         long,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [63:0]  msg_word,
  input  logic         msg_last,
  input  logic [3:0]   msg_bytes,
  output logic         busy,
  output logic [63:0]  tag,
  output logic         tag_valid,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [127:0] core_key,
  output logic [63:0]  core_mi,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  input  logic         core_ready,
  input  logic [127:0] core_word,
  input  logic         core_word_valid,
  output logic [3:0]   dbg_state
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_INIT       = 4'd1;
  localparam logic [3:0] ST_ACCEPT     = 4'd2;
  localparam logic [3:0] ST_COMP_ISSUE = 4'd3;
  localparam logic [3:0] ST_COMP_WAIT  = 4'd4;
  localparam logic [3:0] ST_PAD_ISSUE  = 4'd5;
  localparam logic [3:0] ST_PAD_WAIT   = 4'd6;
  localparam logic [3:0] ST_FIN_ISSUE  = 4'd7;
  localparam logic [3:0] ST_FIN_WAIT   = 4'd8;

  // Handshake: a message word transfers on a rising clk edge where
  // msg_valid and msg_ready are both 1; msg_ready depends only on state.

  logic [3:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic         long_q, long_d;
  logic [7:0]   len_q, len_d;
  logic [63:0]  mi_q, mi_d;
  logic         pad_pending_q, pad_pending_d;
  logic         skip_q, skip_d;
  logic [63:0]  tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;
  logic         init_q, init_d;
  logic         comp_q, comp_d;
  logic         fin_q, fin_d;

  logic [3:0]   msg_b;
  logic [7:0]   len_sum;
  logic [63:0]  byte_mask;
  logic [63:0]  pad_blk;
  logic [63:0]  unused_word_hi;

  assign unused_word_hi = core_word[127:64];

  // Last-word byte count, clamped to 8, and the merged tail/length block.
  always_comb begin
    msg_b = 4'd8;
    if (msg_last && (msg_bytes < 4'd8)) msg_b = msg_bytes;
    len_sum   = len_q + {4'd0, msg_b};
    byte_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < msg_b) byte_mask[8*i +: 8] = 8'hff;
    end
    pad_blk = {len_sum, 56'h0} | (msg_word & byte_mask);
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    long_d        = long_q;
    len_d         = len_q;
    mi_d          = mi_q;
    pad_pending_d = pad_pending_q;
    skip_d        = skip_q;
    tag_d         = tag_q;
    tag_valid_d   = tag_valid_q;
    init_d        = 1'b0;
    comp_d        = 1'b0;
    fin_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d         = key;
          long_d        = long;
          len_d         = 8'd0;
          pad_pending_d = 1'b0;
          tag_valid_d   = 1'b0;
          state_d       = ST_INIT;
        end
      end
      ST_INIT: begin
        if (core_ready) begin
          init_d  = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (msg_valid) begin
          len_d = len_sum;
          if (!msg_last || (msg_b == 4'd8)) begin
            mi_d          = msg_word;
            pad_pending_d = msg_last;
            state_d       = ST_COMP_ISSUE;
          end else begin
            mi_d    = pad_blk;
            state_d = ST_PAD_ISSUE;
          end
        end
      end
      ST_COMP_ISSUE: begin
        if (core_ready) begin
          comp_d  = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_COMP_WAIT;
        end
      end
      // The core lowers ready one cycle after the strobe, so the first
      // wait cycle still shows the stale ready and must be skipped.
      ST_COMP_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (core_ready) begin
          if (pad_pending_q) begin
            mi_d          = {len_q, 56'h0};
            pad_pending_d = 1'b0;
            state_d       = ST_PAD_ISSUE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_PAD_ISSUE: begin
        if (core_ready) begin
          comp_d  = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_PAD_WAIT;
        end
      end
      ST_PAD_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (core_ready) begin
          state_d = ST_FIN_ISSUE;
        end
      end
      ST_FIN_ISSUE: begin
        if (core_ready) begin
          fin_d   = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_FIN_WAIT;
        end
      end
      ST_FIN_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (core_ready && core_word_valid) begin
          tag_d       = core_word[63:0];
          tag_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      long_q        <= 1'b0;
      len_q         <= 8'd0;
      mi_q          <= '0;
      pad_pending_q <= 1'b0;
      skip_q        <= 1'b0;
      tag_q         <= '0;
      tag_valid_q   <= 1'b0;
      init_q        <= 1'b0;
      comp_q        <= 1'b0;
      fin_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      long_q        <= long_d;
      len_q         <= len_d;
      mi_q          <= mi_d;
      pad_pending_q <= pad_pending_d;
      skip_q        <= skip_d;
      tag_q         <= tag_d;
      tag_valid_q   <= tag_valid_d;
      init_q        <= init_d;
      comp_q        <= comp_d;
      fin_q         <= fin_d;
    end
  end

  assign msg_ready               = (state_q == ST_ACCEPT);
  assign busy                    = (state_q != ST_IDLE);
  assign tag                     = tag_q;
  assign tag_valid               = tag_valid_q;
  assign core_initalize          = init_q;
  assign core_compress           = comp_q;
  assign core_finalize           = fin_q;
  assign core_long               = long_q;
  assign core_key                = key_q;
  assign core_mi                 = mi_q;
  assign core_compression_rounds = C_ROUNDS[3:0];
  assign core_final_rounds       = D_ROUNDS[3:0];
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Bench for siphash_msg_ctrl: a behavioural SipHash core on the core side,
// a byte-level SipHash reference, and a scoreboard of expected blocks and tags.
module tb_siphash_msg_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, lng_s, msg_valid, msg_ready, msg_last, busy, tag_valid;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic         core_ready, core_word_valid;
  logic [127:0] key_s, core_key, core_word;
  logic [63:0]  msg_word, tag, core_mi;
  logic [3:0]   msg_bytes, core_compression_rounds, core_final_rounds, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_mi_q[$];
  logic [7:0]  msg_q[$];

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  siphash_msg_ctrl #(.C_ROUNDS(2), .D_ROUNDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key_s), .long(lng_s),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_word(msg_word),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .busy(busy), .tag(tag),
    .tag_valid(tag_valid), .core_initalize(core_initalize),
    .core_compress(core_compress), .core_finalize(core_finalize),
    .core_long(core_long), .core_key(core_key), .core_mi(core_mi),
    .core_compression_rounds(core_compression_rounds),
    .core_final_rounds(core_final_rounds), .core_ready(core_ready),
    .core_word(core_word), .core_word_valid(core_word_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- SipHash arithmetic ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [255:0] sip_round(input logic [255:0] s);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = s;
    v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
    v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
    v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
    v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] sip_init(input logic [127:0] k, input logic lng);
    logic [63:0] v0, v1, v2, v3;
    v0 = k[63:0]   ^ 64'h736f6d6570736575;
    v1 = k[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
    v2 = k[63:0]   ^ 64'h6c7967656e657261;
    v3 = k[127:64] ^ 64'h7465646279746573;
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] sip_compress(input logic [255:0] s, input logic [63:0] m, input int rounds);
    logic [255:0] t;
    t = s;
    t[255:192] = t[255:192] ^ m;
    for (int i = 0; i < rounds; i++) t = sip_round(t);
    t[63:0] = t[63:0] ^ m;
    return t;
  endfunction

  function automatic logic [63:0] sip_final(input logic [255:0] s, input logic lng, input int rounds);
    logic [255:0] t;
    t = s;
    t[191:128] = t[191:128] ^ (lng ? 64'hee : 64'hff);
    for (int i = 0; i < rounds; i++) t = sip_round(t);
    return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
  endfunction

  // Reference: standard SipHash-2-4 over the byte string in msg_q.
  task automatic ref_message(input logic [127:0] k, input logic lng, output logic [63:0] t);
    logic [255:0] s;
    logic [63:0]  m;
    int           n;
    n = msg_q.size();
    s = sip_init(k, lng);
    for (int blk = 0; blk <= n / 8; blk++) begin
      m = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * blk + j < n) m[8*j +: 8] = msg_q[8 * blk + j];
      end
      if (blk == n / 8) m[63:56] = n[7:0];
      exp_mi_q.push_back(m);
      s = sip_compress(s, m, 2);
    end
    t = sip_final(s, lng, 4);
  endtask

  // ---------------- behavioural core ----------------
  logic [255:0] cv;
  logic [63:0]  cw;
  int           ccnt;
  bit           pend_fin;
  logic         s_init, s_comp, s_fin, s_long;
  logic [63:0]  s_mi;
  logic [127:0] s_key;
  logic [3:0]   s_cr, s_fr;

  initial begin
    core_ready = 1'b1; core_word_valid = 1'b0; core_word = '0;
    cv = '0; cw = '0; ccnt = 0; pend_fin = 1'b0;
    forever begin
      @(negedge clk);
      s_init = core_initalize; s_comp = core_compress; s_fin = core_finalize;
      s_mi = core_mi; s_key = core_key; s_long = core_long;
      s_cr = core_compression_rounds; s_fr = core_final_rounds;
      if (s_init || s_comp || s_fin) chk1("core_idle_at_cmd", ccnt == 0, 1'b1);
      @(posedge clk);
      #1;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          core_ready = 1'b1;
          if (pend_fin) begin
            core_word_valid = 1'b1;
            core_word = {~cw, cw};
            pend_fin = 1'b0;
          end
        end
      end
      if (s_init) begin
        cv = sip_init(s_key, s_long);
        core_word_valid = 1'b0;
      end else if (s_comp) begin
        cv = sip_compress(cv, s_mi, int'(s_cr));
        ccnt = int'($urandom_range(1, 5));
        core_ready = 1'b0; core_word_valid = 1'b0;
      end else if (s_fin) begin
        cw = sip_final(cv, s_long, int'(s_fr));
        pend_fin = 1'b1;
        ccnt = int'($urandom_range(1, 5));
        core_ready = 1'b0; core_word_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_tv = 1'b0;
  bit          track = 1'b0;
  logic [63:0] held_mi = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tv = 1'b0;
        track = 1'b0;
      end else begin
        chk1("strobe_onehot0", $onehot0({core_initalize, core_compress, core_finalize}), 1'b1);
        if (msg_ready) begin
          chk1("ready_implies_busy", busy, 1'b1);
          chk1("ready_no_cmp_fin", core_compress | core_finalize, 1'b0);
        end
        if (track) begin
          if (ccnt != 0) chk64("mi_stable", core_mi, held_mi);
          else track = 1'b0;
        end
        if (core_compress) begin
          if (exp_mi_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL compress_unexpected: got mi %h expected no compress", core_mi);
          end else begin
            chk64("compress_mi", core_mi, exp_mi_q.pop_front());
          end
          track = 1'b1;
          held_mi = core_mi;
        end
        if (tag_valid && !prev_tv) begin
          chk1("idle_at_tag", busy, 1'b0);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tag_unexpected: got %h expected no tag", tag);
          end else begin
            chk64("tag", tag, exp_q.pop_front());
          end
        end
        prev_tv = tag_valid;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_message(input logic [127:0] k, input logic lng, input int n,
                             input bit tail_zero, input bit seq_data, input bit use_kat,
                             input logic [63:0] kat, input int bubble, input bit abort);
    logic [63:0] rtag, w;
    int          words, lb, guard, b;
    bit          is_last;
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(seq_data ? 8'(i) : 8'($urandom_range(0, 255)));
    ref_message(k, lng, rtag);
    exp_q.push_back(use_kat ? kat : rtag);

    guard = 0;
    @(negedge clk);
    while (busy && guard < 3000) begin @(negedge clk); guard++; end
    if (busy) chk1("idle_timeout", busy, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; key_s = k; lng_s = lng;
    @(posedge clk); #1;
    start = 1'b0;

    lb = n % 8;
    if (lb == 0 && n > 0 && !tail_zero) begin words = n / 8; lb = 8; end
    else words = n / 8 + 1;

    for (int wi = 0; wi < words; wi++) begin
      is_last = (wi == words - 1);
      b = is_last ? lb : 8;
      for (int j = 0; j < 8; j++)
        w[8*j +: 8] = (j < b) ? msg_q[8 * wi + j] : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, bubble)) begin
        start = 1'($urandom_range(0, 1));
        key_s = {$urandom, $urandom, $urandom, $urandom};
        lng_s = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      msg_valid = 1'b1; msg_word = w; msg_last = is_last;
      msg_bytes = is_last ? ((b == 8) ? 4'($urandom_range(8, 15)) : 4'(b)) : 4'($urandom_range(0, 15));
      guard = 0;
      do begin @(negedge clk); guard++; end while (!msg_ready && guard < 3000);
      if (!msg_ready) begin
        chk1("accept_timeout", msg_ready, 1'b1);
        msg_valid = 1'b0; start = 1'b0;
        exp_q.delete(); exp_mi_q.delete();
        return;
      end
      @(posedge clk); #1;
      msg_valid = 1'b0; msg_last = 1'b0; start = 1'b0;
      if (abort && wi == 0) begin
        guard = 0;
        do begin @(negedge clk); guard++; end while (!core_compress && guard < 100);
        chk1("abort_saw_compress", core_compress, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete(); exp_mi_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_tag_valid", tag_valid, 1'b0);
        chk1("abort_msg_ready", msg_ready, 1'b0);
        chk64("abort_core_mi", core_mi, 64'h0);
        chk1("abort_strobes", core_initalize | core_compress | core_finalize, 1'b0);
        return;
      end
    end
    key_s = {$urandom, $urandom, $urandom, $urandom};

    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin @(negedge clk); guard++; end
    if (exp_q.size() != 0) begin
      chk1("tag_timeout", exp_q.size() == 0, 1'b1);
      exp_q.delete(); exp_mi_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; key_s = '0; lng_s = 1'b0;
    msg_valid = 1'b0; msg_word = '0; msg_last = 1'b0; msg_bytes = '0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; key_s = KAT_KEY;
    @(negedge clk);
    chk1("rst_msg_ready", msg_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_tag", tag, 64'h0);
    chk1("rst_tag_valid", tag_valid, 1'b0);
    chk1("rst_strobes", core_initalize | core_compress | core_finalize, 1'b0);
    chk64("rst_core_mi", core_mi, 64'h0);
    chk1("rst_core_key", core_key == 128'h0, 1'b1);
    chk1("rst_core_long", core_long, 1'b0);
    chk64("c_rounds", 64'(core_compression_rounds), 64'd2);
    chk64("d_rounds", 64'(core_final_rounds), 64'd4);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;

    run_message(KAT_KEY, 1'b0, 0,  1'b0, 1'b1, 1'b1, 64'h726fdb47dd0e0e31, 0, 1'b0);
    run_message(KAT_KEY, 1'b0, 8,  1'b0, 1'b1, 1'b1, 64'h93f5f5799a932462, 0, 1'b0);
    run_message(KAT_KEY, 1'b0, 15, 1'b0, 1'b1, 1'b1, 64'ha129ca6149be45e5, 0, 1'b0);
    run_message(KAT_KEY, 1'b0, 15, 1'b0, 1'b1, 1'b1, 64'ha129ca6149be45e5, 4, 1'b0);
    run_message(KAT_KEY, 1'b0, 8,  1'b1, 1'b1, 1'b1, 64'h93f5f5799a932462, 2, 1'b0);
    run_message(KAT_KEY, 1'b0, 264, 1'b1, 1'b0, 1'b0, 64'h0, 1, 1'b0);
    run_message(KAT_KEY, 1'b0, 16, 1'b0, 1'b0, 1'b0, 64'h0, 2, 1'b1);
    run_message(KAT_KEY, 1'b0, 0,  1'b0, 1'b1, 1'b1, 64'h726fdb47dd0e0e31, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      run_message({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                  64'h0, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk64("mi_queue_drained", 64'(exp_mi_q.size()), 64'd0);
    chk64("tag_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
